// File: rtl/pkt_pack.sv
// Packet packer: walks a linked list of SRAM blocks for one tagged packet, streams
// the words out with sop/eop, and returns each block to the free list once it has been read.
module pkt_pack #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iTagVld,
    output logic          oTagRdy,
    input  logic [AW-1:0] iTagFirAddr,
    input  logic [3:0]    iTagBlkNum,
    input  logic [3:0]    iTagLastWords,
    output logic          oLinkRdEn,
    output logic [AW-1:0] oLinkRdAddr,
    input  logic [AW-1:0] iLinkData,
    output logic          oMemRdEn,
    output logic [AW+3:0] oMemRdAddr,
    input  logic [DW-1:0] iMemRdData,
    output logic          oTxVld,
    output logic          oTxSop,
    output logic          oTxEop,
    output logic [DW-1:0] oTxData,
    input  logic          iTxRdy,
    output logic          oFreeAddrVld,
    output logic [AW-1:0] oFreeAddr,
    input  logic          iFreeAddrRdy,
    output logic          oDone
);

    typedef enum logic [1:0] {StIdle, StRd, StFree, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cur_blk_q, cur_blk_d;
    logic [AW-1:0] nxt_blk_q, nxt_blk_d;
    logic [3:0]    word_idx_q, word_idx_d;
    logic [3:0]    blk_cnt_q, blk_cnt_d;
    logic [3:0]    blk_num_q, blk_num_d;
    logic [3:0]    last_words_q, last_words_d;
    logic          link_pend_q, rd_if_q, rd_sop_q, rd_eop_q;

    logic [DW+1:0] fifo_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    cnt_q, cnt_d;

    logic          tag_rdy, mem_rd_en, link_rd_en, free_vld, done;
    logic          is_last_blk, is_last_word, push, pop, can_issue;
    logic [4:0]    word_lim;
    logic [2:0]    occ;
    logic [DW+1:0] head;

    assign is_last_blk  = (blk_cnt_q == blk_num_q);
    assign word_lim     = (is_last_blk && last_words_q != 4'd0) ? {1'b0, last_words_q} : 5'd16;
    assign is_last_word = (({1'b0, word_idx_q} + 5'd1) == word_lim);
    assign push         = rd_if_q;
    assign pop          = (cnt_q != 2'd0) && iTxRdy;
    // Counting this cycle's pop lets a read issue every cycle while the stream flows.
    assign occ          = {1'b0, cnt_q} + {2'b00, rd_if_q} - {2'b00, pop};
    assign can_issue    = (occ < 3'd2);
    assign cnt_d        = cnt_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d      = state_q;
        cur_blk_d    = cur_blk_q;
        nxt_blk_d    = link_pend_q ? iLinkData : nxt_blk_q;
        word_idx_d   = word_idx_q;
        blk_cnt_d    = blk_cnt_q;
        blk_num_d    = blk_num_q;
        last_words_d = last_words_q;
        tag_rdy      = 1'b0;
        mem_rd_en    = 1'b0;
        link_rd_en   = 1'b0;
        free_vld     = 1'b0;
        done         = 1'b0;
        case (state_q)
            StIdle: begin
                tag_rdy = 1'b1;
                if (iTagVld) begin
                    cur_blk_d    = iTagFirAddr;
                    blk_num_d    = iTagBlkNum;
                    last_words_d = iTagLastWords;
                    word_idx_d   = 4'd0;
                    blk_cnt_d    = 4'd0;
                    state_d      = StRd;
                end
            end
            StRd: begin
                if (can_issue) begin
                    mem_rd_en  = 1'b1;
                    link_rd_en = (word_idx_q == 4'd0) && !is_last_blk;
                    word_idx_d = word_idx_q + 4'd1;
                    if (is_last_word) begin
                        state_d = StFree;
                    end
                end
            end
            StFree: begin
                free_vld = 1'b1;
                if (iFreeAddrRdy) begin
                    if (is_last_blk) begin
                        state_d = StDrain;
                    end else begin
                        cur_blk_d  = nxt_blk_q;
                        word_idx_d = 4'd0;
                        blk_cnt_d  = blk_cnt_q + 4'd1;
                        state_d    = StRd;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == 2'd0 && !rd_if_q) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= StIdle;
            cur_blk_q    <= '0;
            nxt_blk_q    <= '0;
            word_idx_q   <= 4'd0;
            blk_cnt_q    <= 4'd0;
            blk_num_q    <= 4'd0;
            last_words_q <= 4'd0;
            link_pend_q  <= 1'b0;
            rd_if_q      <= 1'b0;
            rd_sop_q     <= 1'b0;
            rd_eop_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            cur_blk_q    <= cur_blk_d;
            nxt_blk_q    <= nxt_blk_d;
            word_idx_q   <= word_idx_d;
            blk_cnt_q    <= blk_cnt_d;
            blk_num_q    <= blk_num_d;
            last_words_q <= last_words_d;
            link_pend_q  <= link_rd_en;
            rd_if_q      <= mem_rd_en;
            rd_sop_q     <= (blk_cnt_q == 4'd0) && (word_idx_q == 4'd0);
            rd_eop_q     <= is_last_blk && is_last_word;
            wr_ptr_q     <= wr_ptr_q ^ push;
            rd_ptr_q     <= rd_ptr_q ^ pop;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {rd_sop_q, rd_eop_q, iMemRdData};
        end
    end

    assign head = fifo_q[rd_ptr_q];

    // Every output is forced low while reset is held.
    assign oTagRdy      = tag_rdy & ~iRst;
    assign oLinkRdEn    = link_rd_en & ~iRst;
    assign oLinkRdAddr  = iRst ? '0 : cur_blk_q;
    assign oMemRdEn     = mem_rd_en & ~iRst;
    assign oMemRdAddr   = iRst ? '0 : {cur_blk_q, word_idx_q};
    assign oTxVld       = (cnt_q != 2'd0) & ~iRst;
    assign oTxSop       = oTxVld & head[DW+1];
    assign oTxEop       = oTxVld & head[DW];
    assign oTxData      = oTxVld ? head[DW-1:0] : '0;
    assign oFreeAddrVld = free_vld & ~iRst;
    assign oFreeAddr    = iRst ? '0 : cur_blk_q;
    assign oDone        = done & ~iRst;

endmodule
